aes_key_expand: RTL

Iterative AES key-schedule engine that sits directly upstream of AES_Encrypt. It takes a 128/192/256-bit cipher key and generates all round keys, one 32-bit schedule word per clock, into an internal word array. Round keys are read out by round index for the encrypt datapath. It is parameterised with the same KEY_LEN/NR/NK triple as AES_Encrypt, so instances pair one-to-one.

---
 rtl/aes_pkg.sv | 19 +
 rtl/aes_key_expand_if.sv | 22 ++
 rtl/aes_sbox.sv | 30 +++
 rtl/aes_key_expand.sv | 102 ++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES constants, FSM encoding and GF(2^8) helpers.
// Imported by the key schedule and the encrypt datapath.
package aes_pkg;

    localparam int AES_WORD = 32;
    localparam logic [7:0] RCON_INIT = 8'h01;
    localparam logic [7:0] RED_POLY  = 8'h1b;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        DONE   = 2'd2
    } state_t;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? RED_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/aes_key_expand_if.sv
// Key-schedule request/readout bundle.
// Master drives start/key/index; slave returns status and round key.
interface aes_key_expand_if #(
    parameter int KEY_LEN = 128
);
    logic               start;
    logic [KEY_LEN-1:0] key_in;
    logic               busy;
    logic               keys_valid;
    logic [3:0]         rk_idx;
    logic [127:0]       rk_out;

    modport master (
        output start, key_in, rk_idx,
        input  busy, keys_valid, rk_out
    );

    modport slave (
        input  start, key_in, rk_idx,
        output busy, keys_valid, rk_out
    );
endinterface

// File: rtl/aes_sbox.sv
// Combinational FIPS-197 forward S-box.
// Shared by SubWord here and SubBytes in the encrypt datapath.
module aes_sbox (
    input  logic [7:0] a,
    output logic [7:0] y
);
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    logic [10:0] base;

    assign base = 11'd2047 - {a, 3'b000};
    assign y    = SBOX[base -: 8];
endmodule

// File: rtl/aes_key_expand.sv
// Iterative AES key schedule: one 32-bit word per clock into a word array.
// Round keys are read combinationally by index for the encrypt datapath.
module aes_key_expand
    import aes_pkg::*;
#(
    parameter int KEY_LEN = 128,
    parameter int NR      = 10,
    parameter int NK      = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    aes_key_expand_if.slave  bus
);
    localparam int         W       = 4 * (NR + 1);
    localparam logic [5:0] LAST    = 6'(W - 1);
    localparam logic [2:0] PH_LAST = 3'(NK - 1);

    state_t              state;
    logic [5:0]          i;
    logic [2:0]          phase;
    logic [7:0]          rcon;
    logic [AES_WORD-1:0] w [W];

    logic [5:0]          ip;
    logic [5:0]          ib;
    logic [AES_WORD-1:0] prev;
    logic [AES_WORD-1:0] back;
    logic [AES_WORD-1:0] sin;
    logic [AES_WORD-1:0] sout;
    logic [AES_WORD-1:0] temp;

    assign ip   = i - 6'd1;
    assign ib   = i - 6'(NK);
    assign prev = w[ip];
    assign back = w[ib];

    // phase 0 substitutes the rotated word, phase 4 (256-bit only) the plain word
    assign sin = (phase == 3'd0) ? {prev[23:0], prev[31:24]} : prev;

    for (genvar b = 0; b < 4; b++) begin : g_sub
        aes_sbox u_sbox (
            .a (sin[8*b +: 8]),
            .y (sout[8*b +: 8])
        );
    end

    always_comb begin
        temp = prev;
        if (phase == 3'd0)
            temp = sout ^ {rcon, 24'h0};
        else if (NK == 8 && phase == 3'd4)
            temp = sout;
    end

    always_comb begin
        bus.rk_out = '0;
        if (bus.rk_idx <= 4'(NR))
            bus.rk_out = {w[{bus.rk_idx, 2'b00}], w[{bus.rk_idx, 2'b01}],
                          w[{bus.rk_idx, 2'b10}], w[{bus.rk_idx, 2'b11}]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            i              <= '0;
            phase          <= '0;
            rcon           <= RCON_INIT;
            bus.busy       <= 1'b0;
            bus.keys_valid <= 1'b0;
            for (int k = 0; k < W; k++)
                w[k] <= '0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        for (int k = 0; k < NK; k++)
                            w[k] <= bus.key_in[KEY_LEN-1-32*k -: 32];
                        i              <= 6'(NK);
                        phase          <= '0;
                        rcon           <= RCON_INIT;
                        bus.keys_valid <= 1'b0;
                        bus.busy       <= 1'b1;
                        state          <= EXPAND;
                    end
                end
                EXPAND: begin
                    w[i]  <= back ^ temp;
                    i     <= i + 6'd1;
                    phase <= (phase == PH_LAST) ? 3'd0 : phase + 3'd1;
                    if (phase == 3'd0)
                        rcon <= xtime(rcon);
                    if (i == LAST) begin
                        bus.busy       <= 1'b0;
                        bus.keys_valid <= 1'b1;
                        state          <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
